// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Byte-serial memory controller that arbitrates between an
//               instruction-fetch port and a MEM-stage load/store port and
//               drives a byte-wide synchronous RAM.
//               Ports:
//                 clk, rst            - clock, synchronous active-low reset
//                 if_req, if_addr     - 4-byte instruction fetch request
//                 rw_in, addr_in,
//                 data_length_in,
//                 data_in             - MEM-stage load/store request
//                 busy_out, done_out,
//                 IF_or_MEM, data_out - status and completion result
//                 mem_a, mem_dout,
//                 mem_din, mem_wr     - byte-wide RAM interface
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic [1:0]  rw_in,
    input  logic [31:0] addr_in,
    input  logic [2:0]  data_length_in,
    input  logic [31:0] data_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [1:0]  IF_or_MEM,
    output logic [31:0] data_out,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_wr
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_base;
    logic [2:0]  r_len;
    logic [2:0]  r_cnt;
    logic [31:0] r_data;
    logic [31:0] r_buf;
    logic        r_owner_if;
    logic        r_is_write;

    logic [2:0]  w_len_dec;
    logic [31:0] w_addr;
    logic [1:0]  w_buf_idx;
    logic        w_mem_rd_req;
    logic        w_mem_wr_req;

    // Only 1, 2 and 4 byte transfers exist; anything else is a full word.
    always_comb begin
        w_len_dec = 3'd4;
        case (data_length_in)
            3'b001:  w_len_dec = 3'd1;
            3'b010:  w_len_dec = 3'd2;
            default: w_len_dec = 3'd4;
        endcase
    end

    assign w_mem_rd_req = (rw_in == 2'b01);
    assign w_mem_wr_req = (rw_in == 2'b10);

    // 32-bit add wraps naturally modulo 2^32.
    assign w_addr = r_base + {29'd0, r_cnt};

    // RAM read data lags the address by one cycle, so the byte arriving while
    // cnt=k belongs to buffer slot k-1 (cnt=4 maps to slot 3 via 2-bit wrap).
    assign w_buf_idx = r_cnt[1:0] - 2'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_base     <= 32'd0;
            r_len      <= 3'd0;
            r_cnt      <= 3'd0;
            r_data     <= 32'd0;
            r_buf      <= 32'd0;
            r_owner_if <= 1'b0;
            r_is_write <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_mem_rd_req || w_mem_wr_req) begin
                        r_base     <= addr_in;
                        r_len      <= w_len_dec;
                        r_data     <= data_in;
                        r_owner_if <= 1'b0;
                        r_is_write <= w_mem_wr_req;
                        r_cnt      <= 3'd0;
                        r_buf      <= 32'd0;
                        r_state    <= w_mem_wr_req ? c_WRITE : c_READ;
                    end else if (if_req) begin
                        r_base     <= if_addr;
                        r_len      <= 3'd4;
                        r_data     <= 32'd0;
                        r_owner_if <= 1'b1;
                        r_is_write <= 1'b0;
                        r_cnt      <= 3'd0;
                        r_buf      <= 32'd0;
                        r_state    <= c_READ;
                    end
                end
                c_READ: begin
                    if (r_cnt != 3'd0) begin
                        r_buf[{w_buf_idx, 3'b000} +: 8] <= mem_din;
                    end
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == r_len) begin
                        r_state <= c_DONE;
                    end
                end
                c_WRITE: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == (r_len - 3'd1)) begin
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy_out  = (r_state == c_READ) || (r_state == c_WRITE);
        done_out  = (r_state == c_DONE);
        IF_or_MEM = 2'b00;
        data_out  = 32'd0;
        mem_a     = 32'd0;
        mem_dout  = 8'd0;
        mem_wr    = 1'b0;
        if (r_state == c_DONE) begin
            IF_or_MEM = r_owner_if ? 2'b10 : 2'b01;
            data_out  = r_is_write ? 32'd0 : r_buf;
        end
        // The final READ cycle only collects the last byte; no address is issued.
        if ((r_state == c_READ) && (r_cnt < r_len)) begin
            mem_a = w_addr;
        end
        if (r_state == c_WRITE) begin
            mem_a    = w_addr;
            mem_dout = r_data[{r_cnt[1:0], 3'b000} +: 8];
            mem_wr   = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl with a byte-wide RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [1:0]  rw_in;
    logic [31:0] addr_in;
    logic [2:0]  data_length_in;
    logic [31:0] data_in;
    logic        busy_out;
    logic        done_out;
    logic [1:0]  IF_or_MEM;
    logic [31:0] data_out;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_wr;

    int checks = 0;
    int errors = 0;

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .rw_in          (rw_in),
        .addr_in        (addr_in),
        .data_length_in (data_length_in),
        .data_in        (data_in),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .IF_or_MEM      (IF_or_MEM),
        .data_out       (data_out),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .mem_wr         (mem_wr)
    );

    always #5 clk = ~clk;

    // Byte RAM model: low 10 address bits, one-cycle read latency.
    logic [7:0] ram [1024];
    bit         loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
            ram[10'h100] <= 8'h11;
            ram[10'h101] <= 8'h22;
            ram[10'h102] <= 8'h33;
            ram[10'h103] <= 8'h44;
            ram[10'h3FF] <= 8'hAB;
            ram[10'h000] <= 8'hCD;
            mem_din      <= 8'h00;
            loaded       <= 1'b1;
        end else begin
            if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
            mem_din <= ram[mem_a[9:0]];
        end
    end

    typedef struct {
        logic        ifr;
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        logic [1:0]  owner;
        logic [31:0] rdata;
        int          lat;
        int          nbytes;
        int          wrs;
        logic [31:0] a0;
        logic [31:0] alast;
    } vec_t;

    vec_t vecs[11];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drop_all;
        if_req         = 1'b0;
        rw_in          = 2'b00;
    endtask

    // Presents a request during an IDLE cycle, follows it to DONE, checks the
    // completion, drops the request in the DONE cycle and returns in IDLE.
    task automatic run_txn(input vec_t v, input string tag);
        int          n;
        int          na;
        int          wrs;
        bit          seen;
        logic [31:0] alog[8];
        n = 0; na = 0; wrs = 0; seen = 1'b0;
        for (int i = 0; i < 8; i++) alog[i] = 32'hDEAD_DEAD;
        if (v.ifr) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            rw_in          = v.rw;
            addr_in        = v.addr;
            data_length_in = v.len;
            data_in        = v.wdata;
        end
        while (n < 20 && !seen) begin
            tick;
            n++;
            if (done_out) begin
                seen = 1'b1;
            end else if (busy_out) begin
                if (na < 8) begin
                    alog[na] = mem_a;
                    na++;
                end
                if (mem_wr) wrs++;
            end
        end
        chk({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk({tag, " latency"}, n, v.lat);
            chk({tag, " owner"}, {30'd0, IF_or_MEM}, {30'd0, v.owner});
            chk({tag, " data_out"}, data_out, v.rdata);
            chk({tag, " busy_in_done"}, {31'd0, busy_out}, 32'd0);
            chk({tag, " wr_cycles"}, wrs, v.wrs);
            chk({tag, " first_addr"}, alog[0], v.a0);
            chk({tag, " last_addr"}, alog[v.nbytes - 1], v.alast);
        end
        drop_all;
        tick;
        chk({tag, " idle_done"}, {31'd0, done_out}, 32'd0);
    endtask

    initial begin
        //          ifr  rw     addr           len     wdata          own    rdata         lat nb wr a0             alast
        vecs[0]  = '{1'b0, 2'b01, 32'h0000_0100, 3'b100, 32'h0,         2'b01, 32'h4433_2211, 6, 4, 0, 32'h0000_0100, 32'h0000_0103};
        vecs[1]  = '{1'b0, 2'b10, 32'h0000_0203, 3'b001, 32'hDEAD_BEEF, 2'b01, 32'h0,         2, 1, 1, 32'h0000_0203, 32'h0000_0203};
        vecs[2]  = '{1'b0, 2'b01, 32'hFFFF_FFFF, 3'b010, 32'h0,         2'b01, 32'h0000_CDAB, 4, 2, 0, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3]  = '{1'b1, 2'b00, 32'h0000_0100, 3'b000, 32'h0,         2'b10, 32'h4433_2211, 6, 4, 0, 32'h0000_0100, 32'h0000_0103};
        vecs[4]  = '{1'b0, 2'b01, 32'h0000_0100, 3'b011, 32'h0,         2'b01, 32'h4433_2211, 6, 4, 0, 32'h0000_0100, 32'h0000_0103};
        vecs[5]  = '{1'b0, 2'b10, 32'h0000_0110, 3'b100, 32'h0102_0304, 2'b01, 32'h0,         5, 4, 4, 32'h0000_0110, 32'h0000_0113};
        vecs[6]  = '{1'b0, 2'b01, 32'h0000_0112, 3'b001, 32'h0,         2'b01, 32'h0000_0002, 3, 1, 0, 32'h0000_0112, 32'h0000_0112};
        vecs[7]  = '{1'b0, 2'b10, 32'h0000_0120, 3'b010, 32'hAAAA_5566, 2'b01, 32'h0,         3, 2, 2, 32'h0000_0120, 32'h0000_0121};
        vecs[8]  = '{1'b1, 2'b00, 32'h0000_0120, 3'b000, 32'h0,         2'b10, 32'h0000_5566, 6, 4, 0, 32'h0000_0120, 32'h0000_0123};
        vecs[9]  = '{1'b0, 2'b01, 32'h0000_0101, 3'b010, 32'h0,         2'b01, 32'h0000_3322, 4, 2, 0, 32'h0000_0101, 32'h0000_0102};
        vecs[10] = '{1'b0, 2'b01, 32'h0000_0110, 3'b000, 32'h0,         2'b01, 32'h0102_0304, 6, 4, 0, 32'h0000_0110, 32'h0000_0113};

        rst = 1'b0; if_req = 1'b0; if_addr = 32'd0; rw_in = 2'b00;
        addr_in = 32'd0; data_length_in = 3'b000; data_in = 32'd0;
        repeat (3) tick;
        chk("reset busy", {31'd0, busy_out}, 32'd0);
        chk("reset done", {31'd0, done_out}, 32'd0);
        chk("reset owner", {30'd0, IF_or_MEM}, 32'd0);
        chk("reset data_out", data_out, 32'd0);
        chk("reset mem_a", mem_a, 32'd0);
        chk("reset mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("reset mem_dout", {24'd0, mem_dout}, 32'd0);
        rst = 1'b1;
        tick;

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
            if (i == 1) begin
                chk("store byte ram[203]", {24'd0, ram[10'h203]}, 32'h0000_00EF);
                chk("store byte ram[204]", {24'd0, ram[10'h204]}, 32'h0000_0000);
            end
        end

        // Illegal rw code 11: no transaction starts.
        rw_in = 2'b11; addr_in = 32'h100; data_length_in = 3'b100;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rw11 busy", {31'd0, busy_out}, 32'd0);
        end
        rw_in = 2'b00;
        tick;

        // Contention: MEM wins, IF follows after MEM's DONE.
        begin
            int n;
            rw_in = 2'b01; addr_in = 32'h100; data_length_in = 3'b100;
            if_req = 1'b1; if_addr = 32'h120;
            n = 0;
            while (n < 20 && !done_out) begin tick; n++; end
            chk("contend first latency", n, 6);
            chk("contend first owner", {30'd0, IF_or_MEM}, 32'h1);
            chk("contend first data", data_out, 32'h4433_2211);
            rw_in = 2'b00;
            tick;
            chk("contend idle busy", {31'd0, busy_out}, 32'd0);
            n = 0;
            while (n < 20 && !done_out) begin tick; n++; end
            chk("contend second latency", n, 6);
            chk("contend second owner", {30'd0, IF_or_MEM}, 32'h2);
            chk("contend second data", data_out, 32'h0000_5566);
            if_req = 1'b0;
            tick;
        end

        // Reset during the second byte of a word store.
        rw_in = 2'b10; addr_in = 32'h130; data_length_in = 3'b100; data_in = 32'h1122_3344;
        tick;
        chk("rstwr byte1 mem_wr", {31'd0, mem_wr}, 32'd1);
        tick;
        chk("rstwr byte2 mem_a", mem_a, 32'h0000_0131);
        rst = 1'b0;
        rw_in = 2'b01; addr_in = 32'h130; data_length_in = 3'b010;
        tick;
        chk("rstwr mem_wr after", {31'd0, mem_wr}, 32'd0);
        chk("rstwr busy after", {31'd0, busy_out}, 32'd0);
        chk("rstwr done after", {31'd0, done_out}, 32'd0);
        tick;
        chk("rstwr held req ignored", {31'd0, busy_out}, 32'd0);
        chk("rstwr no done", {31'd0, done_out}, 32'd0);
        chk("rstwr ram[130]", {24'd0, ram[10'h130]}, 32'h0000_0044);
        chk("rstwr ram[131]", {24'd0, ram[10'h131]}, 32'h0000_0033);
        chk("rstwr ram[132]", {24'd0, ram[10'h132]}, 32'h0000_0000);
        rst = 1'b1;
        run_txn('{1'b0, 2'b01, 32'h0000_0130, 3'b010, 32'h0, 2'b01, 32'h0000_3344,
                  4, 2, 0, 32'h0000_0130, 32'h0000_0131}, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
